slice_sequencer: RTL and testbench
==================================

# slice_sequencer

Parametrised, handshake-driven successor to the fixed-schedule slice sequencer. It walks a frame of `slice_num` slices. For each slice it runs the header writer, then `NUM_COMP` component encoders in turn (Y, Cb, Cr, optional alpha). It waits on done strobes instead of fixed cycle budgets, accumulates byte counts, and emits size patch-back writes to the bitstream writer over a valid/ready queue. Zero-valued sizes are patched like any other value.

## Interface
Parameters:
- `NUM_COMP`, 3: components per slice, 2..4; component 0 is Y.
- `Y_BLOCKS`, 32: Y blocks per slice.
- `C_BLOCKS`, 16: blocks per chroma or alpha component.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame start request; ignored unless state is IDLE.
- `slice_num` in 32: number of slices; sampled at accepted `start`.
- `slice_size_table_size` in 32: slice table bytes; sampled at accepted `start`.
- `picture_size_offset_addr`, `frame_size_offset_addr` in 32 each: patch addresses; sampled at accepted `start`.
- `slice_size_offset_addr`, `comp_size_offset_addr` in 32 each: per-slice patch addresses; sampled at `header_done`.
- `set_bit_total_byte_size` in 32: byte count of the active stream since its last reset.
- `header_done` in 1: header writer finished; qualified only in HDR.
- `comp_done` in 1: component encoder finished; qualified only in COMP.
- `header_reset_n` out 1: active-low hold for the header writer.
- `component_reset_n` out 1: active-low hold for the component encoder.
- `comp_idx` out 2: current component.
- `is_y` out 1: high when `comp_idx == 0`.
- `offset` out 32: coefficient buffer offset of the current component.
- `block_num` out 32: block count of the current component.
- `slice_idx` out 32: current slice.
- `busy` out 1: high when not in IDLE.
- `frame_done` out 1: one-cycle pulse at frame end.
- `patch_valid` out 1, `patch_ready` in 1: patch handshake.
- `patch_addr` out 32, `patch_val` out 32, `patch_byte_size` out 32: patch payload.

## Operation
States and transitions:
- IDLE:
  - Accepted `start` with `slice_num != 0` goes to HDR.
  - Accepted `start` with `slice_num == 0` goes to FRAME_END.
- HDR: `header_reset_n = 1`. On `header_done`, capture `hdr = set_bit_total_byte_size`; for slice 0 use `set_bit_total_byte_size - slice_size_table_size` instead. Go to HDR_GAP.
- HDR_GAP: lasts one cycle with both resets low. Set `comp_idx = 0` and `slice_acc = hdr`. Go to COMP.
- COMP: `component_reset_n = 1`. On `comp_done`, capture `c = set_bit_total_byte_size`, set `slice_acc += c`, and set `pending_comp[comp_idx]` with value `c` when `comp_idx < NUM_COMP-1`. The last component is implied and never patched. Go to CGAP.
- CGAP: lasts one cycle with `component_reset_n` low.
  - If this was the last component, go to SLICE_END.
  - Otherwise increment `comp_idx` and go to COMP.
- SLICE_END:
  - Set `pending_slice` with value `slice_acc` and add `slice_acc` to `frame_acc`.
  - Stay until every pending flag is clear.
  - Then, if `slice_idx + 1 < slice_num`, increment `slice_idx` and go to HDR; otherwise go to FRAME_END.
- FRAME_END:
  - Set `frame_val = frame_acc + slice_size_table_size` and `picture_val = frame_val - picture_size_offset_addr + 1`, and set both pending flags.
  - When the queue drains, pulse `frame_done` and go to IDLE.

Component outputs:
- `offset = 0` for Y; `offset = Y_BLOCKS*64 + (k-1)*C_BLOCKS*64` for k ≥ 1 (0, 2048, 3072, 4096 at defaults).
- `block_num = Y_BLOCKS` for Y, `C_BLOCKS` otherwise.

Patch queue:
- Uses pending flags, not zero tests, so a zero size is still written.
- Priority: slice, then picture, then frame, then comp 0..NUM_COMP-2.
- Slice and comp patches use `patch_byte_size = 2`; picture and frame use 4.
- Comp k address = `comp_size_offset_addr + 2k`.

Arithmetic: all 32-bit, wrapping modulo 2^32. The writer uses the low `patch_byte_size` bytes of `patch_val`.

## Timing
- Reset values:
  - All pending flags and accumulators 0; state IDLE.
  - `header_reset_n = 0`, `component_reset_n = 0`, `comp_idx = 0`, `is_y = 1`, `offset = 0`, `block_num = Y_BLOCKS`, `slice_idx = 0`.
  - `busy = 0`, `frame_done = 0`, `patch_valid = 0`, `patch_addr = 0`, `patch_val = 0`, `patch_byte_size = 0`.
- All outputs are registered.
- `start` at edge t: `header_reset_n` rises at t+1.
- `header_done` at edge t: `header_reset_n` is low for t+1; `component_reset_n` rises at t+2.
- `comp_done` at t: `component_reset_n` is low for exactly one cycle (t+1); the next component's hold releases at t+2.
- Patch handshake:
  - A pending entry is presented one cycle after its flag is set.
  - Transfer occurs on `patch_valid && patch_ready`; the flag clears at that edge and the next entry is presented on the following cycle.
  - Payload is held stable while `valid && !ready`.
- A done strobe outside its qualifying state is ignored.
- Because the FSM waits in SLICE_END for an empty queue, no pending flag is ever overwritten.
- `reset_n` asserted mid-frame: all state returns to reset values immediately and queued patches are discarded.

## Test plan
- Single slice, `NUM_COMP = 3`, table 0x10, header total 0x130, comps 0x200/0x100/0x80, picture address 0x14, `ready` tied high:
  - Patches in order: comp0 0x200 (2B), comp1 0x100 (2B), slice 0x4A0 (2B), picture 0x49D (4B), frame 0x4B0 (4B).
  - Then `frame_done`.
- Component outputs: with `NUM_COMP = 4`, the offsets and `block_num` sequence is 0/32, 2048/16, 3072/16, 4096/16; comp 2 is patched at `comp_size_offset_addr + 4`.
- Zero size: comp0 size 0 -> patch with `val = 0` is still issued.
- Backpressure: `patch_ready` low for 20 cycles at SLICE_END -> payload stable, FSM holds in SLICE_END, next HDR starts only after the drain.
- Multi-slice:
  - `slice_num = 3` -> three slice patches, then `frame_val = Σslice + table`.
  - `start` pulsed while busy is ignored.
  - `slice_num = 0` -> only picture and frame patches.
- Reset asserted during COMP of slice 1 -> all outputs return to reset values and no patches remain queued.

Source files
------------

// File: rtl/slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : slice_sequencer
// Purpose  : Handshake-driven slice sequencer. Walks a frame slice by slice,
//            running the header writer and NUM_COMP component encoders,
//            accumulating byte counts and issuing size patch-back writes over
//            a valid/ready queue.
// Revision : 1.0 - initial release
// ============================================================================
module slice_sequencer #(
  parameter int NUM_COMP = 3,
  parameter int Y_BLOCKS = 32,
  parameter int C_BLOCKS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] slice_num,
  input  logic [31:0] slice_size_table_size,
  input  logic [31:0] picture_size_offset_addr,
  input  logic [31:0] frame_size_offset_addr,
  input  logic [31:0] slice_size_offset_addr,
  input  logic [31:0] comp_size_offset_addr,
  input  logic [31:0] set_bit_total_byte_size,
  input  logic        header_done,
  input  logic        comp_done,
  output logic        header_reset_n,
  output logic        component_reset_n,
  output logic [1:0]  comp_idx,
  output logic        is_y,
  output logic [31:0] offset,
  output logic [31:0] block_num,
  output logic [31:0] slice_idx,
  output logic        busy,
  output logic        frame_done,
  output logic        patch_valid,
  input  logic        patch_ready,
  output logic [31:0] patch_addr,
  output logic [31:0] patch_val,
  output logic [31:0] patch_byte_size
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_HDR_GAP   = 3'd2,
    S_COMP      = 3'd3,
    S_CGAP      = 3'd4,
    S_SLICE_END = 3'd5,
    S_FRAME_END = 3'd6
  } state_t;

  // Components whose size is patched; the last one is implied by the slice size.
  localparam int          NPC       = NUM_COMP - 1;
  localparam logic [1:0]  LAST_COMP = 2'(NUM_COMP - 1);
  localparam logic [31:0] Y_OFFSET  = 32'(Y_BLOCKS * 64);
  localparam logic [31:0] C_STRIDE  = 32'(C_BLOCKS * 64);
  localparam logic [2:0]  SEL_SLICE = 3'd0;
  localparam logic [2:0]  SEL_PIC   = 3'd1;
  localparam logic [2:0]  SEL_FRAME = 3'd2;
  localparam logic [2:0]  SEL_COMP0 = 3'd3;

  state_t      state, next_state;

  logic [31:0] slice_cnt, table_size, pic_addr, frm_addr;
  logic [31:0] slice_addr, comp_addr;
  logic [31:0] hdr_size, slice_acc, frame_acc;
  logic [31:0] slice_val, pic_val, frame_val;
  logic [31:0] comp_val [NPC];
  logic        pending_slice, pending_pic, pending_frame;
  logic [NPC-1:0] pending_comp;
  logic        frame_armed;
  logic [2:0]  patch_sel;

  logic        any_pending, xfer;
  logic        hdr_run, comp_run, done_now;
  logic        arb_found;
  logic [2:0]  arb_sel;
  logic [31:0] arb_addr, arb_val, arb_size;

  assign any_pending = pending_slice | pending_pic | pending_frame | (|pending_comp);
  assign xfer        = patch_valid & patch_ready;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic and the state-decoded controls that get registered.
  always_comb begin
    next_state = state;
    hdr_run    = 1'b0;
    comp_run   = 1'b0;
    done_now   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (slice_num != 32'd0) ? S_HDR : S_FRAME_END;
      end
      S_HDR: begin
        hdr_run = 1'b1;
        if (header_done) next_state = S_HDR_GAP;
      end
      S_HDR_GAP: next_state = S_COMP;
      S_COMP: begin
        comp_run = 1'b1;
        if (comp_done) next_state = S_CGAP;
      end
      S_CGAP: next_state = (comp_idx == LAST_COMP) ? S_SLICE_END : S_COMP;
      S_SLICE_END: begin
        if (!any_pending) next_state = (slice_idx + 32'd1 < slice_cnt) ? S_HDR : S_FRAME_END;
      end
      S_FRAME_END: begin
        if (frame_armed && !any_pending) begin
          done_now   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Patch arbiter: fixed priority over pending flags, skipping the entry that
  // is completing this cycle so back-to-back transfers are possible.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = SEL_SLICE;
    arb_addr  = 32'd0;
    arb_val   = 32'd0;
    arb_size  = 32'd0;
    if (pending_slice && !(xfer && patch_sel == SEL_SLICE)) begin
      arb_found = 1'b1;
      arb_sel   = SEL_SLICE;
      arb_addr  = slice_addr;
      arb_val   = slice_val;
      arb_size  = 32'd2;
    end else if (pending_pic && !(xfer && patch_sel == SEL_PIC)) begin
      arb_found = 1'b1;
      arb_sel   = SEL_PIC;
      arb_addr  = pic_addr;
      arb_val   = pic_val;
      arb_size  = 32'd4;
    end else if (pending_frame && !(xfer && patch_sel == SEL_FRAME)) begin
      arb_found = 1'b1;
      arb_sel   = SEL_FRAME;
      arb_addr  = frm_addr;
      arb_val   = frame_val;
      arb_size  = 32'd4;
    end else begin
      // Walk downward so the lowest-numbered pending component wins.
      for (int k = NPC - 1; k >= 0; k--) begin
        if (pending_comp[k] && !(xfer && patch_sel == SEL_COMP0 + 3'(k))) begin
          arb_found = 1'b1;
          arb_sel   = SEL_COMP0 + 3'(k);
          arb_addr  = comp_addr + 32'(2 * k);
          arb_val   = comp_val[k];
          arb_size  = 32'd2;
        end
      end
    end
  end

  // Datapath: captured parameters, accumulators, pending flags and outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slice_cnt         <= 32'd0;
      table_size        <= 32'd0;
      pic_addr          <= 32'd0;
      frm_addr          <= 32'd0;
      slice_addr        <= 32'd0;
      comp_addr         <= 32'd0;
      hdr_size          <= 32'd0;
      slice_acc         <= 32'd0;
      frame_acc         <= 32'd0;
      slice_val         <= 32'd0;
      pic_val           <= 32'd0;
      frame_val         <= 32'd0;
      for (int k = 0; k < NPC; k++) comp_val[k] <= 32'd0;
      pending_slice     <= 1'b0;
      pending_pic       <= 1'b0;
      pending_frame     <= 1'b0;
      pending_comp      <= '0;
      frame_armed       <= 1'b0;
      header_reset_n    <= 1'b0;
      component_reset_n <= 1'b0;
      comp_idx          <= 2'd0;
      is_y              <= 1'b1;
      offset            <= 32'd0;
      block_num         <= 32'(Y_BLOCKS);
      slice_idx         <= 32'd0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      header_reset_n    <= hdr_run;
      component_reset_n <= comp_run;
      frame_done        <= done_now;
      busy              <= (next_state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            slice_cnt  <= slice_num;
            table_size <= slice_size_table_size;
            pic_addr   <= picture_size_offset_addr;
            frm_addr   <= frame_size_offset_addr;
            slice_idx  <= 32'd0;
            frame_acc  <= 32'd0;
          end
        end
        S_HDR: begin
          if (header_done) begin
            slice_addr <= slice_size_offset_addr;
            comp_addr  <= comp_size_offset_addr;
            // The first slice's header count also includes the slice table.
            hdr_size   <= (slice_idx == 32'd0) ? set_bit_total_byte_size - table_size
                                               : set_bit_total_byte_size;
          end
        end
        S_HDR_GAP: begin
          comp_idx  <= 2'd0;
          is_y      <= 1'b1;
          offset    <= 32'd0;
          block_num <= 32'(Y_BLOCKS);
          slice_acc <= hdr_size;
        end
        S_COMP: begin
          if (comp_done) begin
            slice_acc <= slice_acc + set_bit_total_byte_size;
            for (int k = 0; k < NPC; k++) begin
              if (comp_idx == 2'(k)) begin
                pending_comp[k] <= 1'b1;
                comp_val[k]     <= set_bit_total_byte_size;
              end
            end
          end
        end
        S_CGAP: begin
          if (comp_idx == LAST_COMP) begin
            pending_slice <= 1'b1;
            slice_val     <= slice_acc;
            frame_acc     <= frame_acc + slice_acc;
          end else begin
            comp_idx  <= comp_idx + 2'd1;
            is_y      <= 1'b0;
            offset    <= Y_OFFSET + {30'd0, comp_idx} * C_STRIDE;
            block_num <= 32'(C_BLOCKS);
          end
        end
        S_SLICE_END: begin
          if (!any_pending && (slice_idx + 32'd1 < slice_cnt)) slice_idx <= slice_idx + 32'd1;
        end
        S_FRAME_END: begin
          if (!frame_armed) begin
            frame_val     <= frame_acc + table_size;
            pic_val       <= frame_acc + table_size - pic_addr + 32'd1;
            pending_pic   <= 1'b1;
            pending_frame <= 1'b1;
            frame_armed   <= 1'b1;
          end else if (!any_pending) begin
            frame_armed <= 1'b0;
          end
        end
        default: ;
      endcase
      // A flag is never set while it is pending, so clearing here cannot
      // collide with a set in the same cycle.
      if (xfer) begin
        if (patch_sel == SEL_SLICE) pending_slice <= 1'b0;
        if (patch_sel == SEL_PIC)   pending_pic   <= 1'b0;
        if (patch_sel == SEL_FRAME) pending_frame <= 1'b0;
        for (int k = 0; k < NPC; k++) begin
          if (patch_sel == SEL_COMP0 + 3'(k)) pending_comp[k] <= 1'b0;
        end
      end
    end
  end

  // Patch output register: loads a new entry whenever the slot is free or
  // the current entry completes, and holds the payload under backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      patch_valid     <= 1'b0;
      patch_sel       <= SEL_SLICE;
      patch_addr      <= 32'd0;
      patch_val       <= 32'd0;
      patch_byte_size <= 32'd0;
    end else if (!patch_valid || patch_ready) begin
      patch_valid <= arb_found;
      if (arb_found) begin
        patch_sel       <= arb_sel;
        patch_addr      <= arb_addr;
        patch_val       <= arb_val;
        patch_byte_size <= arb_size;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_slice_sequencer
// Purpose  : Directed self-checking bench for slice_sequencer (NUM_COMP = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_slice_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] slice_num, slice_size_table_size;
  logic [31:0] picture_size_offset_addr, frame_size_offset_addr;
  logic [31:0] slice_size_offset_addr, comp_size_offset_addr;
  logic [31:0] set_bit_total_byte_size;
  logic        header_done, comp_done;
  logic        header_reset_n, component_reset_n;
  logic [1:0]  comp_idx;
  logic        is_y;
  logic [31:0] offset, block_num, slice_idx;
  logic        busy, frame_done;
  logic        patch_valid, patch_ready;
  logic [31:0] patch_addr, patch_val, patch_byte_size;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] b;
  } patch_t;

  patch_t got_q[$];
  patch_t exp_q[$];
  logic [31:0] cs [4];
  logic [31:0] exp_off [4] = '{32'd0, 32'd2048, 32'd3072, 32'd4096};
  logic [31:0] exp_bn  [4] = '{32'd32, 32'd16, 32'd16, 32'd16};
  int vectors;
  int miscompares;

  slice_sequencer #(.NUM_COMP(4), .Y_BLOCKS(32), .C_BLOCKS(16)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .start                    (start),
    .slice_num                (slice_num),
    .slice_size_table_size    (slice_size_table_size),
    .picture_size_offset_addr (picture_size_offset_addr),
    .frame_size_offset_addr   (frame_size_offset_addr),
    .slice_size_offset_addr   (slice_size_offset_addr),
    .comp_size_offset_addr    (comp_size_offset_addr),
    .set_bit_total_byte_size  (set_bit_total_byte_size),
    .header_done              (header_done),
    .comp_done                (comp_done),
    .header_reset_n           (header_reset_n),
    .component_reset_n        (component_reset_n),
    .comp_idx                 (comp_idx),
    .is_y                     (is_y),
    .offset                   (offset),
    .block_num                (block_num),
    .slice_idx                (slice_idx),
    .busy                     (busy),
    .frame_done               (frame_done),
    .patch_valid              (patch_valid),
    .patch_ready              (patch_ready),
    .patch_addr               (patch_addr),
    .patch_val                (patch_val),
    .patch_byte_size          (patch_byte_size)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Record every completed patch transfer, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n && patch_valid && patch_ready)
      got_q.push_back({patch_addr, patch_val, patch_byte_size});
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string p);
    check_value({p, "_hdr_rst_n"},  32'(header_reset_n),    32'd0);
    check_value({p, "_comp_rst_n"}, 32'(component_reset_n), 32'd0);
    check_value({p, "_comp_idx"},   32'(comp_idx),          32'd0);
    check_value({p, "_is_y"},       32'(is_y),              32'd1);
    check_value({p, "_offset"},     offset,                 32'd0);
    check_value({p, "_block_num"},  block_num,              32'd32);
    check_value({p, "_slice_idx"},  slice_idx,              32'd0);
    check_value({p, "_busy"},       32'(busy),              32'd0);
    check_value({p, "_frame_done"}, 32'(frame_done),        32'd0);
    check_value({p, "_pvalid"},     32'(patch_valid),       32'd0);
    check_value({p, "_paddr"},      patch_addr,             32'd0);
    check_value({p, "_pval"},       patch_val,              32'd0);
    check_value({p, "_psize"},      patch_byte_size,        32'd0);
  endtask

  task automatic wait_hdr(output int n);
    n = 0;
    while (header_reset_n !== 1'b1 && n < 200) begin step(); n++; end
    check_value("hdr_release", 32'(header_reset_n), 32'd1);
  endtask

  task automatic wait_comp(output int n);
    n = 0;
    while (component_reset_n !== 1'b1 && n < 200) begin step(); n++; end
    check_value("comp_release", 32'(component_reset_n), 32'd1);
  endtask

  task automatic wait_frame_done(input string p);
    int n = 0;
    while (frame_done !== 1'b1 && n < 300) begin step(); n++; end
    check_value({p, "_frame_done"}, 32'(frame_done), 32'd1);
    check_value({p, "_busy_low"},   32'(busy),       32'd0);
  endtask

  task automatic start_frame(input logic [31:0] num, input logic [31:0] tbl,
                             input logic [31:0] pa, input logic [31:0] fa);
    slice_num                = num;
    slice_size_table_size    = tbl;
    picture_size_offset_addr = pa;
    frame_size_offset_addr   = fa;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [31:0] v, input logic [31:0] b);
    exp_q.push_back({a, v, b});
  endtask

  task automatic compare_patches(input string p);
    check_value({p, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check_value($sformatf("%s_p%0d_addr", p, i), got_q[i].a, exp_q[i].a);
        check_value($sformatf("%s_p%0d_val",  p, i), got_q[i].v, exp_q[i].v);
        check_value($sformatf("%s_p%0d_size", p, i), got_q[i].b, exp_q[i].b);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Drive one slice: header then four components with sizes from cs[].
  task automatic run_slice(input logic [31:0] exp_slice, input logic [31:0] hdr_tot,
                           input logic [31:0] s_addr, input logic [31:0] c_addr,
                           input bit timing, input bit bp);
    int n;
    int errs;
    int hdr_seen;
    logic [31:0] ha, hv, hb;
    wait_hdr(n);
    if (timing) check_value("start_to_hdr", 32'(n), 32'd1);
    check_value("slice_idx", slice_idx, exp_slice);
    slice_size_offset_addr  = s_addr;
    comp_size_offset_addr   = c_addr;
    set_bit_total_byte_size = hdr_tot;
    header_done = 1'b1;
    step();
    header_done = 1'b0;
    step();
    if (timing) begin
      check_value("hgap_hdr_rst_n",  32'(header_reset_n),    32'd0);
      check_value("hgap_comp_rst_n", 32'(component_reset_n), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_comp(n);
      if (timing) check_value($sformatf("comp%0d_release_lat", k), 32'(n), 32'd1);
      check_value($sformatf("comp%0d_idx", k),    32'(comp_idx), 32'(k));
      check_value($sformatf("comp%0d_is_y", k),   32'(is_y),     (k == 0) ? 32'd1 : 32'd0);
      check_value($sformatf("comp%0d_offset", k), offset,        exp_off[k]);
      check_value($sformatf("comp%0d_blocks", k), block_num,     exp_bn[k]);
      repeat (k + 1) step();
      set_bit_total_byte_size = cs[k];
      comp_done = 1'b1;
      step();
      comp_done = 1'b0;
      if (k == 3 && bp) patch_ready = 1'b0;
      step();
      if (timing) check_value($sformatf("cgap%0d_comp_rst_n", k), 32'(component_reset_n), 32'd0);
    end
    if (bp) begin
      step();
      check_value("bp_valid", 32'(patch_valid), 32'd1);
      ha = patch_addr; hv = patch_val; hb = patch_byte_size;
      errs = 0;
      hdr_seen = 0;
      repeat (20) begin
        step();
        if (patch_valid !== 1'b1 || patch_addr !== ha || patch_val !== hv || patch_byte_size !== hb)
          errs++;
        if (header_reset_n !== 1'b0 || slice_idx !== exp_slice) hdr_seen++;
      end
      check_value("bp_payload_stable", 32'(errs), 32'd0);
      check_value("bp_fsm_holds",      32'(hdr_seen), 32'd0);
      patch_ready = 1'b1;
    end
  endtask

  initial begin
    int n;
    int hits;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start = 1'b0;
    slice_num = 32'd0;
    slice_size_table_size = 32'd0;
    picture_size_offset_addr = 32'd0;
    frame_size_offset_addr = 32'd0;
    slice_size_offset_addr = 32'd0;
    comp_size_offset_addr = 32'd0;
    set_bit_total_byte_size = 32'd0;
    header_done = 1'b0;
    comp_done = 1'b0;
    patch_ready = 1'b1;
    repeat (3) step();
    check_reset_state("rst");
    reset_n = 1'b1;
    step();

    // Frame 1: single slice, exact timing checks, ready high.
    cs = '{32'h200, 32'h100, 32'h80, 32'h40};
    start_frame(32'd1, 32'h10, 32'h14, 32'h18);
    run_slice(32'd0, 32'h130, 32'h40, 32'h50, 1'b1, 1'b0);
    wait_frame_done("f1");
    exp_push(32'h50, 32'h200, 32'd2);
    exp_push(32'h52, 32'h100, 32'd2);
    exp_push(32'h54, 32'h80,  32'd2);
    exp_push(32'h40, 32'h4E0, 32'd2);
    exp_push(32'h14, 32'h4DD, 32'd4);
    exp_push(32'h18, 32'h4F0, 32'd4);
    compare_patches("f1");

    // Frame 2: three slices, zero-size comp, ignored start, backpressure.
    start_frame(32'd3, 32'h20, 32'h100, 32'h104);
    cs = '{32'h0, 32'h10, 32'h20, 32'h30};
    run_slice(32'd0, 32'h60, 32'h1000, 32'h2000, 1'b0, 1'b0);
    check_value("f2_busy", 32'(busy), 32'd1);
    slice_num = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    slice_num = 32'd3;
    cs = '{32'h100, 32'h0, 32'h4, 32'h8};
    run_slice(32'd1, 32'h08, 32'h1010, 32'h2010, 1'b0, 1'b1);
    cs = '{32'h1, 32'h2, 32'h3, 32'h4};
    run_slice(32'd2, 32'h10, 32'h1020, 32'h2020, 1'b0, 1'b0);
    wait_frame_done("f2");
    exp_push(32'h2000, 32'h0,   32'd2);
    exp_push(32'h2002, 32'h10,  32'd2);
    exp_push(32'h2004, 32'h20,  32'd2);
    exp_push(32'h1000, 32'hA0,  32'd2);
    exp_push(32'h2010, 32'h100, 32'd2);
    exp_push(32'h2012, 32'h0,   32'd2);
    exp_push(32'h2014, 32'h4,   32'd2);
    exp_push(32'h1010, 32'h114, 32'd2);
    exp_push(32'h2020, 32'h1,   32'd2);
    exp_push(32'h2022, 32'h2,   32'd2);
    exp_push(32'h2024, 32'h3,   32'd2);
    exp_push(32'h1020, 32'h1A,  32'd2);
    exp_push(32'h100,  32'hEF,  32'd4);
    exp_push(32'h104,  32'h1EE, 32'd4);
    compare_patches("f2");

    // Frame 3: zero slices, only picture and frame patches.
    start_frame(32'd0, 32'h8, 32'h3, 32'h7);
    wait_frame_done("f3");
    exp_push(32'h3, 32'h6, 32'd4);
    exp_push(32'h7, 32'h8, 32'd4);
    compare_patches("f3");

    // Frame 4: reset asserted during a component of slice 1.
    cs = '{32'h1, 32'h2, 32'h3, 32'h4};
    start_frame(32'd2, 32'h0, 32'h10, 32'h20);
    run_slice(32'd0, 32'h10, 32'h300, 32'h400, 1'b0, 1'b0);
    wait_hdr(n);
    set_bit_total_byte_size = 32'h20;
    header_done = 1'b1;
    step();
    header_done = 1'b0;
    step();
    wait_comp(n);
    patch_ready = 1'b0;
    set_bit_total_byte_size = 32'h55;
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    repeat (3) step();
    check_value("rs_queued", 32'(patch_valid), 32'd1);
    wait_comp(n);
    check_value("rs_comp_idx", 32'(comp_idx), 32'd1);
    got_q.delete();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    step();
    reset_n = 1'b1;
    patch_ready = 1'b1;
    hits = 0;
    repeat (10) begin
      step();
      if (patch_valid === 1'b1) hits++;
    end
    check_value("post_rst_valid", 32'(hits), 32'd0);
    check_value("post_rst_queue", 32'(got_q.size()), 32'd0);
    check_value("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
